// File: rtl/enc_onehot_to_bin_pipe.sv
// enc_onehot_to_bin_pipe
// One-hot to binary encoder behind a 2-entry skid buffer (OUT + SKID).
// Any input that is not exactly one-hot still produces the index of its lowest
// set bit (0 for an all-zero word).
// Optional legality checker and saturating error counter, built only when
// ENC_OHOT_CHK_EN is defined. Without it, err_o and err_cnt_o are tied to 0.
module enc_onehot_to_bin_pipe #(
   parameter int OHOT_WTH   = 8,
   parameter int BIN_WTH    = 3,
   parameter int ERRCNT_WTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_vld_i,
   output logic                  in_rdy_o,
   input  logic [OHOT_WTH-1:0]   data_i,
   output logic                  out_vld_o,
   input  logic                  out_rdy_i,
   output logic [BIN_WTH-1:0]    data_o,
   output logic                  err_o,
   input  logic                  clr_i,
   output logic [ERRCNT_WTH-1:0] err_cnt_o
);

   logic [OHOT_WTH-1:0] lowest_bit;
   logic [BIN_WTH-1:0]  enc_idx;
   logic                enc_err;

   logic                out_vld_q;
   logic [BIN_WTH-1:0]  out_data_q;
   logic                out_err_q;
   logic                skid_vld_q;
   logic [BIN_WTH-1:0]  skid_data_q;
   logic                skid_err_q;

   logic                in_xfer;
   logic                out_free;

   // Isolate the lowest set bit, then OR together the indices of set bits.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      lowest_bit = data_i & (~data_i + OHOT_WTH'(1));
      enc_idx    = '0;
      for (int k = 0; k < OHOT_WTH; k++) begin
         if (lowest_bit[k]) enc_idx = enc_idx | BIN_WTH'(k);
      end
   end

`ifdef ENC_OHOT_CHK_EN
   // Illegal when zero or when more than one bit is set.
   assign enc_err = (data_i == '0) || ((data_i & (data_i - OHOT_WTH'(1))) != '0);
`else
   assign enc_err = 1'b0;
`endif

   // Ready comes straight from the SKID flag register.
   assign in_rdy_o = ~skid_vld_q;
   assign in_xfer  = in_vld_i & ~skid_vld_q;
   // OUT can take a new word when it is empty or being drained this cycle.
   assign out_free = ~out_vld_q | out_rdy_i;

   // Skid-buffer state: refill OUT from SKID first, otherwise from the input.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else if (out_free) begin
         if (skid_vld_q) begin
            out_vld_q  <= 1'b1;
            out_data_q <= skid_data_q;
            out_err_q  <= skid_err_q;
            skid_vld_q <= 1'b0;
         end else if (in_xfer) begin
            out_vld_q  <= 1'b1;
            out_data_q <= enc_idx;
            out_err_q  <= enc_err;
         end else begin
            // Data and flag hold their last value while invalid.
            out_vld_q <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_vld_q  <= 1'b1;
         skid_data_q <= enc_idx;
         skid_err_q  <= enc_err;
      end
   end

   assign out_vld_o = out_vld_q;
   assign data_o    = out_data_q;
   assign err_o     = out_err_q;

`ifdef ENC_OHOT_CHK_EN
   logic [ERRCNT_WTH-1:0] err_cnt_q;

   // Saturating count of accepted illegal words; clear wins over increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         err_cnt_q <= '0;
      end else if (in_xfer && enc_err && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERRCNT_WTH'(1);
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   logic unused_clr;

   // Counter not built: clear input has no effect.
   assign unused_clr = clr_i;
   assign err_cnt_o  = '0;
`endif

endmodule

// File: doc/enc_onehot_to_bin_pipe.md
ENC_ONEHOT_TO_BIN_PIPE -- requirements
Module: enc_onehot_to_bin_pipe

Interface
REQ-001 SHALL have parameter OHOT_WTH, default 8, one-hot input width.
REQ-002 SHALL have parameter BIN_WTH, default 3, binary output width; OHOT_WTH <= 2**BIN_WTH.
REQ-003 SHALL have parameter ERRCNT_WTH, default 16, error counter width.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 in_vld_i  input  1  input word valid.
REQ-007 in_rdy_o  output  1  block can accept an input word.
REQ-008 data_i  input  OHOT_WTH  one-hot input word.
REQ-009 out_vld_o  output  1  output word valid.
REQ-010 out_rdy_i  input  1  downstream accepts output word.
REQ-011 data_o  output  BIN_WTH  encoded binary index.
REQ-012 err_o  output  1  data_o word came from an input that was not exactly one-hot.
REQ-013 clr_i  input  1  synchronous clear of err_cnt_o.
REQ-014 err_cnt_o  output  ERRCNT_WTH  saturating count of accepted illegal words.

Function
REQ-015 Input transfer SHALL occur on a cycle with in_vld_i=1 and in_rdy_o=1; output transfer on out_vld_o=1 and out_rdy_i=1.
REQ-016 Encoding SHALL be: exactly one bit k set -> data_o=k; zero input -> data_o=0; multi-hot -> index of lowest set bit.
REQ-017 Legality flag SHALL be 1 for zero input or more than one bit set, else 0; it travels with its word.
REQ-018 Datapath SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-019 Latency SHALL be 1 cycle: a word accepted in cycle N with OUT empty or draining appears on data_o in cycle N+1.
REQ-020 in_rdy_o SHALL equal NOT SKID-valid, taken directly from a register (no combinational path from out_rdy_i).
REQ-021 On input transfer: if OUT empty or OUT transferring and SKID empty, word loads OUT; otherwise word loads SKID.
REQ-022 On output transfer with SKID valid, SKID contents SHALL move to OUT in the same edge and SKID becomes empty.
REQ-023 Sustained in_vld_i=1 and out_rdy_i=1 SHALL give one word per cycle, no bubbles.
REQ-024 out_rdy_i=0 SHALL hold data_o, err_o, out_vld_o stable; at most one further word is absorbed (SKID), then in_rdy_o=0.
REQ-025 Word order SHALL be preserved; no word dropped or duplicated.
REQ-026 err_cnt_o SHALL increment by 1 per input transfer whose legality flag is 1, saturating at all-ones.
REQ-027 clr_i=1 SHALL set err_cnt_o to 0 next cycle, taking priority over a same-cycle increment.
REQ-028 data_o and err_o SHALL be don't-care-free: hold last value when out_vld_o=0.

Reset
REQ-029 While rst_i=1: OUT-valid=0, SKID-valid=0, data_o=0, err_o=0, err_cnt_o=0; in_rdy_o=1 from the cycle after rst_i is first sampled high.
REQ-030 Input transfers presented while rst_i=1 SHALL be discarded; reset mid-stream SHALL drop all buffered words.
REQ-031 First input transfer SHALL be accepted in the first cycle with rst_i=0.

Configuration
REQ-032 Macro ENC_OHOT_CHK_EN SHALL control the legality checker.
REQ-033 With ENC_OHOT_CHK_EN defined: REQ-017, REQ-026, REQ-027 apply as written.
REQ-034 Without ENC_OHOT_CHK_EN: checker and counter not built; err_o and err_cnt_o tied 0; clr_i ignored; encoding and handshake unchanged.

Verification (OHOT_WTH=8, BIN_WTH=3, ENC_OHOT_CHK_EN defined)
REQ-035 Reset release, out_rdy_i=1, stream 8'h01,8'h02,...,8'h80 back-to-back -> data_o 0..7 on consecutive cycles starting 1 cycle later, err_o=0, err_cnt_o=0.
REQ-036 Send 8'h00 then 8'h0C -> data_o=0,err_o=1 then data_o=2,err_o=1; err_cnt_o=2.
REQ-037 out_rdy_i=0, send 8'h10,8'h20,8'h40 continuously -> 8'h10 in OUT, 8'h20 in SKID, in_rdy_o=0, 8'h40 held; raise out_rdy_i -> outputs 4,5,6 in order.
REQ-038 Force err_cnt_o to 16'hFFFE, send three illegal words -> err_cnt_o 16'hFFFF, stays 16'hFFFF; clr_i with illegal word same cycle -> 0.
REQ-039 Two words buffered, assert rst_i one cycle -> out_vld_o=0, in_rdy_o=1, no buffered word emerges.
REQ-040 Build without ENC_OHOT_CHK_EN, send 8'h00 and 8'hFF -> data_o=0 both, err_o=0, err_cnt_o=0.
